// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t        : arbiter FSM states
//   BE_WORD        : byte-enable pattern of a full-word access
//   BE_NONE        : byte-enable pattern of a write that touches no lane
//   first_state()  : state entered from IDLE for a freshly granted request
package dm_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Reads and full-word writes go straight to memory, empty writes complete
  // without touching memory, anything else needs a read-modify-write.
  function automatic state_t first_state(input logic we, input logic [3:0] be);
    if (!we || be == BE_WORD) return ST_ACCESS;
    else if (be == BE_NONE)   return ST_DONE;
    else                      return ST_RMW_RD;
  endfunction

endpackage

// File: rtl/dm_be_merge.sv
// Byte-lane merge of a new word into an old word.
//   i_old    : word currently held in memory
//   i_new    : lane-aligned store data
//   i_be     : byte enables, bit i selects i_new[8i+7:8i]
//   o_merged : i_new lanes where enabled, i_old lanes elsewhere
module dm_be_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_be,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the MEM
// stage (port 0) and the debug/bridge loader (port 1). Reads and full-word
// writes take one memory cycle; partial stores run a read-modify-write.
//   clk, reset            : clock, asynchronous active-high reset
//   m0_* / m1_*           : req/ack requester ports (req held until ack)
//   mem_re, mem_we        : memory read strobe / write strobe (commit at edge)
//   mem_addr, mem_wdata   : word address (bits[1:0]=0) and write word
//   mem_rdata             : combinational read data from memory
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_buf;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;

  logic        w_any_req;
  logic        w_pick;
  logic        w_req_we;
  logic [3:0]  w_req_be;
  logic        w_grant;
  logic        w_cap_rd;
  logic        w_cap_buf;
  logic [31:0] w_merged;
  logic [31:0] w_word_addr;

  // On a tie the port that was not served last wins; otherwise whoever asks.
  assign w_any_req = m0_req | m1_req;
  assign w_pick    = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_req_we  = w_pick ? m1_we : m0_we;
  assign w_req_be  = w_pick ? m1_be : m0_be;

  dm_be_merge u_merge (
    .i_old    (r_buf),
    .i_new    (r_wdata),
    .i_be     (r_be),
    .o_merged (w_merged)
  );

  // The memory indexes [MEM_AW+1:2]; upper bits are forwarded untouched so
  // the memory can decode them itself.
  assign w_word_addr = r_addr & 32'hFFFF_FFFC;
  assign mem_addr    = {w_word_addr[31:MEM_AW+2], w_word_addr[MEM_AW+1:2],
                        w_word_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Strobes depend on the registered state only, so an asynchronous reset
  // drops them at once and aborts any access in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_cap_rd    = 1'b0;
    w_cap_buf   = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant     = 1'b1;
          w_state_nxt = first_state(w_req_we, w_req_be);
        end
      end
      ST_ACCESS: begin
        mem_re      = ~r_we;
        mem_we      = r_we;
        w_cap_rd    = ~r_we;
        w_state_nxt = ST_DONE;
      end
      ST_RMW_RD: begin
        mem_re      = 1'b1;
        w_cap_buf   = 1'b1;
        w_state_nxt = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_we      = 1'b1;
        mem_wdata   = w_merged;
        w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Latched request and per-port read data. r_last starts at 1 so port 0
  // wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_last  <= w_pick;
        r_owner <= w_pick;
        r_we    <= w_req_we;
        r_addr  <= w_pick ? m1_addr  : m0_addr;
        r_wdata <= w_pick ? m1_wdata : m0_wdata;
        r_be    <= w_req_be;
      end
      if (w_cap_rd) begin
        if (r_owner) r_m1_rdata <= mem_rdata;
        else         r_m0_rdata <= mem_rdata;
      end
    end
  end

  // Merge buffer is pure data; it is always written before being used.
  always_ff @(posedge clk) begin
    if (w_cap_buf) r_buf <= mem_rdata;
  end

  assign m0_ack   = (r_state == ST_DONE) && !r_owner;
  assign m1_ack   = (r_state == ST_DONE) &&  r_owner;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_be = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_be = '0;
  logic        m0_ack, m1_ack, mem_re, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dm_arbiter #(.MEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory: combinational read, synchronous write.
  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  // Bus monitor.
  int          we_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, overlap_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  int          ack_log[$];
  always @(negedge clk) begin
    if (m0_ack && m1_ack) overlap_cnt++;
    if (mem_we) begin
      we_cnt++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (m0_ack) begin ack0_cnt++; ack_log.push_back(0); end
    if (m1_ack) begin ack1_cnt++; ack_log.push_back(1); end
  end

  // Reference model: word-addressed contents, per-port read data, last owner.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd [2];
  int          bench_last;
  int          n_checks = 0, n_pass = 0;

  function automatic void ref_write(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] be);
    int w = int'(addr >> 2);
    logic [31:0] v = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = data[8*i +: 8];
    ref_mem[w] = v;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    int w = int'(addr >> 2);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic int exp_lat(input bit we, input logic [3:0] be);
    if (!we || be == 4'hF) return 2;
    if (be == 4'h0) return 1;
    return 3;
  endfunction

  // One request/ack transaction; entered and left 1 time unit after a rising edge.
  task automatic xact(input int port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rdata, output int lat);
    bit ok = 0;
    if (port == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_req = 1'b1;
    end
    lat = 0;
    while (!ok && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      ok = (port == 0) ? m0_ack : m1_ack;
    end
    rdata = (port == 0) ? m0_rdata : m1_rdata;
    n_checks++;
    if (!ok) $display("FAIL ack_timeout port%0d: no ack after %0d cycles", port, lat);
    else n_pass++;
    @(posedge clk); #1;
    if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  task automatic preload(input int port, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    int l;
    xact(port, 1'b1, addr, data, 4'hF, r, l);
    ref_write(addr, data, 4'hF);
    bench_last = port;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m0_ack, m1_ack, mem_re, mem_we} !== 4'b0)
      $display("FAIL reset_ctrl: got %b required 0000", {m0_ack, m1_ack, mem_re, mem_we});
    else n_pass++;
    n_checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h required 0", {m0_rdata, m1_rdata});
    else n_pass++;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; bench_last = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_write();
    logic [31:0] r;
    int l, w0, a0;
    w0 = we_cnt; a0 = ack0_cnt;
    xact(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, r, l);
    ref_write(32'h10, 32'h1234_5678, 4'hF); bench_last = 0;
    n_checks++;
    if (l !== 2) $display("FAIL fw_latency: got %0d required 2", l); else n_pass++;
    n_checks++;
    if (we_cnt - w0 !== 1) $display("FAIL fw_we_cycles: got %0d required 1", we_cnt - w0); else n_pass++;
    n_checks++;
    if (last_waddr !== 32'h10) $display("FAIL fw_addr: got %h required 00000010", last_waddr); else n_pass++;
    n_checks++;
    if (ack0_cnt - a0 !== 1) $display("FAIL fw_ack_pulses: got %0d required 1", ack0_cnt - a0); else n_pass++;
    n_checks++;
    if (r !== exp_rd[0]) $display("FAIL fw_rdata_kept: got %h required %h", r, exp_rd[0]); else n_pass++;
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, r, l);
    exp_rd[0] = ref_read(32'h10);
    n_checks++;
    if (r !== 32'h1234_5678) $display("FAIL rd_back: got %h required 12345678", r); else n_pass++;
    n_checks++;
    if (l !== 2) $display("FAIL rd_latency: got %0d required 2", l); else n_pass++;
  endtask

  task automatic test_rmw();
    logic [31:0] r;
    int l, w0;
    preload(1, 32'h20, 32'hAABB_CCDD);
    w0 = we_cnt;
    xact(1, 1'b1, 32'h20, 32'h0000_0011, 4'b0001, r, l);
    ref_write(32'h20, 32'h0000_0011, 4'b0001); bench_last = 1;
    n_checks++;
    if (l !== 3) $display("FAIL rmw_latency: got %0d required 3", l); else n_pass++;
    n_checks++;
    if (we_cnt - w0 !== 1) $display("FAIL rmw_we_cycles: got %0d required 1", we_cnt - w0); else n_pass++;
    n_checks++;
    if (last_wdata !== ref_read(32'h20))
      $display("FAIL rmw_wdata: got %h required %h", last_wdata, ref_read(32'h20));
    else n_pass++;
    n_checks++;
    if (last_waddr !== 32'h20) $display("FAIL rmw_addr: got %h required 00000020", last_waddr); else n_pass++;
    n_checks++;
    if (r !== exp_rd[1]) $display("FAIL rmw_rdata_kept: got %h required %h", r, exp_rd[1]); else n_pass++;
  endtask

  task automatic test_be_zero();
    logic [31:0] r, d;
    int l, w0;
    d = $urandom;
    preload(0, 32'h30, d);
    w0 = we_cnt;
    xact(0, 1'b1, 32'h30, ~d, 4'b0000, r, l);
    bench_last = 0;
    n_checks++;
    if (l !== 1) $display("FAIL be0_latency: got %0d required 1", l); else n_pass++;
    n_checks++;
    if (we_cnt - w0 !== 0) $display("FAIL be0_we_cycles: got %0d required 0", we_cnt - w0); else n_pass++;
    xact(1, 1'b0, 32'h30, 32'h0, 4'hF, r, l);
    exp_rd[1] = ref_read(32'h30); bench_last = 1;
    n_checks++;
    if (r !== d) $display("FAIL be0_unchanged: got %h required %h", r, d); else n_pass++;
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] r;
    int l, w0;
    preload(0, 32'h40, 32'h5A5A_1234);
    m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hFFFF_FFFF; m0_be = 4'b0011; m0_req = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_re !== 1'b1) $display("FAIL rmw_rd_strobe: got %b required 1", mem_re); else n_pass++;
    w0 = we_cnt;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_re, mem_we} !== 2'b00) $display("FAIL reset_abort_strobes: got %b required 00", {mem_re, mem_we});
    else n_pass++;
    m0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; bench_last = 1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL post_reset_ack: got %b required 00", {m0_ack, m1_ack});
      else n_pass++;
    end
    n_checks++;
    if (we_cnt - w0 !== 0) $display("FAIL reset_no_write: got %0d required 0", we_cnt - w0); else n_pass++;
    @(posedge clk); #1;
    xact(1, 1'b0, 32'h40, 32'h0, 4'hF, r, l);
    exp_rd[1] = ref_read(32'h40); bench_last = 1;
    n_checks++;
    if (r !== 32'h5A5A_1234) $display("FAIL reset_mem_kept: got %h required 5a5a1234", r); else n_pass++;
  endtask

  task automatic test_read_during_rmw();
    logic [31:0] r0, r1, keep0;
    int l0, l1;
    preload(1, 32'h44, $urandom);
    keep0 = exp_rd[0];
    ack_log.delete();
    fork
      xact(0, 1'b1, 32'h40, 32'hCAFE_0000, 4'b1100, r0, l0);
      begin
        @(posedge clk); #1;
        xact(1, 1'b0, 32'h44, 32'h0, 4'hF, r1, l1);
      end
    join
    ref_write(32'h40, 32'hCAFE_0000, 4'b1100);
    exp_rd[1] = ref_read(32'h44); bench_last = 1;
    n_checks++;
    if (ack_log.size() != 2 || ack_log[0] != 0 || ack_log[1] != 1)
      $display("FAIL busy_order: got %p required '{0, 1}", ack_log);
    else n_pass++;
    n_checks++;
    if (r1 !== exp_rd[1]) $display("FAIL busy_m1_rdata: got %h required %h", r1, exp_rd[1]); else n_pass++;
    n_checks++;
    if (m0_rdata !== keep0) $display("FAIL busy_m0_rdata: got %h required %h", m0_rdata, keep0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int l, first, ov0;
    first = (bench_last == 1) ? 0 : 1;
    ov0 = overlap_cnt;
    ack_log.delete();
    fork
      begin
        logic [31:0] ra; int la;
        for (int i = 0; i < 4; i++) xact(0, 1'b1, 32'h200 + 4*i, 32'hA000_0000 + i, 4'hF, ra, la);
      end
      begin
        logic [31:0] rb; int lb;
        for (int j = 0; j < 4; j++) xact(1, 1'b1, 32'h300 + 4*j, 32'hB000_0000 + j, 4'hF, rb, lb);
      end
    join
    for (int k = 0; k < 4; k++) begin
      ref_write(32'h200 + 4*k, 32'hA000_0000 + k, 4'hF);
      ref_write(32'h300 + 4*k, 32'hB000_0000 + k, 4'hF);
    end
    n_checks++;
    if (ack_log.size() != 8) $display("FAIL rr_count: got %0d required 8", ack_log.size()); else n_pass++;
    for (int k = 0; k < 8 && k < ack_log.size(); k++) begin
      n_checks++;
      if (ack_log[k] != ((first + k) % 2))
        $display("FAIL rr_order[%0d]: got %0d required %0d", k, ack_log[k], (first + k) % 2);
      else n_pass++;
    end
    n_checks++;
    if (overlap_cnt - ov0 != 0) $display("FAIL rr_ack_overlap: got %0d required 0", overlap_cnt - ov0);
    else n_pass++;
    bench_last = 1 - first;
    xact(0, 1'b0, 32'h30C, 32'h0, 4'hF, r, l);
    exp_rd[0] = ref_read(32'h30C); bench_last = 0;
    n_checks++;
    if (r !== exp_rd[0]) $display("FAIL rr_readback: got %h required %h", r, exp_rd[0]); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] r, a, d;
    logic [3:0]  be;
    int l, p;
    bit we;
    for (int i = 0; i < 8; i++) preload(i % 2, 32'h100 + 4*i, $urandom);
    for (int i = 0; i < 24; i++) begin
      p  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      a  = 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      d  = $urandom;
      be = 4'($urandom);
      xact(p, we, a, d, be, r, l);
      if (we) ref_write(a, d, be);
      else exp_rd[p] = ref_read(a);
      bench_last = p;
      n_checks++;
      if (l !== exp_lat(we, be))
        $display("FAIL rnd_latency[%0d]: got %0d required %0d", i, l, exp_lat(we, be));
      else n_pass++;
      n_checks++;
      if (r !== exp_rd[p]) $display("FAIL rnd_rdata[%0d]: got %h required %h", i, r, exp_rd[p]);
      else n_pass++;
      n_checks++;
      if ((p == 0 ? m1_rdata : m0_rdata) !== exp_rd[1-p])
        $display("FAIL rnd_other_rdata[%0d]: got %h required %h", i,
                 (p == 0 ? m1_rdata : m0_rdata), exp_rd[1-p]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_write();
    test_rmw();
    test_be_zero();
    test_reset_mid_rmw();
    test_read_during_rmw();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters:
  - port 0: pipeline MEM stage.
  - port 1: debug/bridge loader.
- Round-robin grant with a req/ack handshake.
- Full-word writes and reads go straight through; byte/halfword stores (sb/sh) run a two-cycle read-modify-write.
- Sits between the MEM stage / loader and the data memory, which has a combinational read and a synchronous write.

Parameters:
- MEM_AW, 10, word-address width forwarded to memory; the word index is addr[MEM_AW+1:2].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 request; held with all fields stable until m0_ack.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  32  port 0 byte address.
- m0_wdata  in  32  port 0 write data, lane-aligned.
- m0_be  in  4  port 0 byte enables; bit i selects wdata[8i+7:8i].
- m0_ack  out  1  port 0 one-cycle completion pulse.
- m0_rdata  out  32  port 0 read data, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_ack, m1_rdata: same as port 0, for port 1.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe, committed at the clk edge.
- mem_addr  out  32  word address to memory, bits[1:0]=0.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset (async, active-high): state=IDLE, last=1 (port 0 wins first tie), both acks 0, both rdata 0, latched request cleared.
- mem_re and mem_we decode combinationally from state, so both drop immediately when reset asserts. A transaction in flight is aborted with no write; the requester must reissue.
- States: IDLE, ACCESS, RMW_RD, RMW_WR, DONE.
- IDLE arbitration:
  - Only one req high: grant it.
  - Both high: grant the port != last.
  - On grant: latch owner, we, addr, wdata, be; set last=owner.
  - Next state:
    - read, or write with be=4'b1111 → ACCESS.
    - write with be=0 → DONE (no memory access).
    - any other write → RMW_RD.
- ACCESS:
  - mem_addr={addr[31:2],2'b00}.
  - Read: mem_re=1, capture mem_rdata into the owner's rdata.
  - Write: mem_we=1, mem_wdata=wdata.
  - Next: DONE.
- RMW_RD: mem_re=1; register mem_rdata into merge buffer; next RMW_WR.
- RMW_WR: mem_we=1; mem_wdata lane i = be[i] ? wdata lane i : buffer lane i; next DONE.
- DONE: owner's ack=1 for exactly this cycle; next IDLE. Acks are decoded from registered state (glitch-free).
- Latency from req sampled at edge k:
  - Full word or read: ack high in the cycle after edge k+1.
  - Partial write: ack high in the cycle after edge k+2.
  - be=0 write: ack high in the cycle after edge k.
- Requester drops or changes req only after seeing ack. IDLE re-arbitrates one cycle later, so back-to-back requests cost one idle cycle each.
- rdata holds its last value until the next read to that port. Write completions leave rdata unchanged.
- Non-owner req is ignored until IDLE. Fairness: alternating grants whenever both ports request continuously.
- No misalignment checking; be is taken as-is. Address bits above MEM_AW+1 pass through unchanged; the memory decodes them.
- Simultaneous events: a req rising during DONE is first sampled in IDLE. Both reqs rising in the same cycle are resolved by last.

Decomposition:
- Shared package: state encoding constants (IDLE..DONE) and constants BE_WORD=4'b1111, BE_NONE=4'b0000.
- One natural sub-module, dm_be_merge: combinational lane merge of (old word, new word, be) → merged word; reusable by the store path later.
- Arbiter FSM stays in dm_arbiter.

Test Plan:
- Reset, then m0 write addr 0x10, data 0x12345678, be 1111 → one cycle of mem_we with mem_addr 0x10; m0_ack pulses once; a later m0 read of 0x10 returns 0x12345678.
- Memory word 0x20 = 0xAABBCCDD; m1 write data 0x00000011, be 0001 → RMW_RD then RMW_WR; mem_wdata 0xAABBCC11; m1_ack one cycle later than a full-word write.
- m0 and m1 raise req in the same cycle, held continuously through 4 requests each → grant order m0, m1, m0, m1, …; no ack overlap.
- m0 write with be 0000 to 0x30 → mem_we never asserts; m0_ack arrives after one cycle; word 0x30 is unchanged.
- Assert reset during RMW_RD of a halfword store to 0x40 → mem_we stays 0; memory 0x40 is unchanged; state is IDLE and acks are 0 after release.
- m1 read of 0x44 issued while m0's RMW to 0x40 is in progress → m1 is granted only after m0_ack; m1_rdata equals the memory word; m0_rdata is unchanged.
